// File: rtl/word_stream_pkg.sv
// word_stream_pkg: shared widths, byte-lane index type and lane selection for word/byte streams
package word_stream_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  typedef logic [1:0] lane_t;
  function automatic logic [BYTE_W-1:0] lane_slice(input logic [WORD_W-1:0] word, input lane_t idx, input logic msb_first);
    lane_t l;
    l = msb_first ? ~idx : idx;
    return word[l*BYTE_W +: BYTE_W];
  endfunction
endpackage

// File: rtl/byte_lane_sel.sv
// byte_lane_sel: combinational 4:1 byte-lane mux, lane order fixed by MSB_FIRST
module byte_lane_sel
  import word_stream_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0] word,
  input  lane_t             idx,
  output logic [BYTE_W-1:0] lane
);
  assign lane = lane_slice(word, idx, MSB_FIRST);
endmodule

// File: rtl/word_to_byte_unpacker.sv
// word_to_byte_unpacker: drains 32-bit words from a read-latency-1 FIFO into a byte FIFO, one byte per clock
module word_to_byte_unpacker
  import word_stream_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic [WORD_W-1:0] in_data,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [BYTE_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);
  logic [WORD_W-1:0] hold, pend;
  logic              hold_valid, pend_valid, inflight;
  lane_t             idx;
  logic              word_done, load_hold, cap_pend;

  assign in_rd_en  = !in_empty && !pend_valid && !inflight;
  assign out_wr_en = hold_valid && !out_full;
  assign word_done = out_wr_en && idx == lane_t'(BYTES_PER_WORD - 1);
  assign load_hold = !hold_valid || word_done;
  // Returning data bypasses pend whenever hold is about to take a word and pend has none.
  assign cap_pend  = inflight && !(load_hold && !pend_valid);
  assign busy      = hold_valid || pend_valid || inflight;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold       <= '0;
      pend       <= '0;
      hold_valid <= 1'b0;
      pend_valid <= 1'b0;
      inflight   <= 1'b0;
      idx        <= '0;
      word_cnt   <= '0;
    end else begin
      inflight <= in_rd_en;
      if (out_wr_en) idx <= idx + lane_t'(1);
      if (word_done) word_cnt <= word_cnt + CNT_W'(1);
      if (load_hold) hold_valid <= pend_valid || inflight;
      if (load_hold && (pend_valid || inflight)) hold <= pend_valid ? pend : in_data;
      if (cap_pend) pend <= in_data;
      pend_valid <= (pend_valid && !load_hold) || cap_pend;
    end

  byte_lane_sel #(.MSB_FIRST(MSB_FIRST)) u_sel (
    .word(hold),
    .idx (idx),
    .lane(out_data)
  );
endmodule

// File: tb/tb_word_to_byte_unpacker.sv
// tb_word_to_byte_unpacker: directed checks of byte order, latency, streaming, backpressure, reset and counter wrap
module tb_word_to_byte_unpacker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_empty = 1'b1;
  logic [31:0] in_data = '0;
  logic        out_full = 1'b0;
  logic        rd0, wr0, busy0, rd1, wr1, busy1;
  logic [7:0]  d0, d1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_busy = 0;
  int full_wr = 0;
  logic rd_s = 1'b0;
  logic [31:0] fq[$];
  logic [7:0]  b0q[$], b1q[$];
  int          wcyc[$], rdq[$];

  word_to_byte_unpacker #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_rd_en(rd0), .in_data(in_data),
    .out_full(out_full), .out_wr_en(wr0), .out_data(d0), .busy(busy0), .word_cnt(cnt0)
  );
  word_to_byte_unpacker #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_rd_en(rd1), .in_data(in_data),
    .out_full(out_full), .out_wr_en(wr1), .out_data(d1), .busy(busy1), .word_cnt(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (rd_s) begin
      in_data  <= fq.pop_front();
      in_empty <= fq.size() == 0;
    end

  always @(negedge clk) begin
    rd_s = rd0;
    if (wr0) begin
      b0q.push_back(d0);
      wcyc.push_back(cyc);
      if (out_full) full_wr++;
    end
    if (wr1) b1q.push_back(d1);
    if (rd0) rdq.push_back(cyc);
    if (busy0) last_busy = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    in_empty = 1'b0;
  endtask

  task automatic clear_obs();
    b0q.delete(); b1q.delete(); wcyc.delete(); rdq.delete();
    full_wr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    in_empty = 1'b1;
    out_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic drain(input int max, input string name);
    int n = 0;
    while ((busy0 || fq.size() != 0) && n < max) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= max) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", name, busy0, n);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rd0, wr0, busy0, d0, cnt0} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_msb: rd=%0b wr=%0b busy=%0b data=%h cnt=%0d, required all 0", rd0, wr0, busy0, d0, cnt0);
    end
    vectors++;
    if ({rd1, wr1, busy1, d1, cnt1} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_lsb: rd=%0b wr=%0b busy=%0b data=%h cnt=%0d, required all 0", rd1, wr1, busy1, d1, cnt1);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] e[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    push(32'hAABBCCDD);
    drain(40, "single");
    vectors++;
    if (b0q.size() !== 4 || b1q.size() !== 4) begin
      miscompares++;
      $display("FAIL single_count: msb=%0d lsb=%0d bytes, required 4", b0q.size(), b1q.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b0q[i] !== e[i]) begin
        miscompares++;
        $display("FAIL single_msb_byte%0d: got %h, required %h", i, b0q[i], e[i]);
      end
      vectors++;
      if (b1q[i] !== e[3-i]) begin
        miscompares++;
        $display("FAIL single_lsb_byte%0d: got %h, required %h", i, b1q[i], e[3-i]);
      end
    end
    vectors++;
    if (wcyc[0] - rdq[0] !== 2) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles, required 2", wcyc[0] - rdq[0]);
    end
    vectors++;
    if (wcyc[3] - wcyc[0] !== 3) begin
      miscompares++;
      $display("FAIL single_contig: span %0d cycles, required 3", wcyc[3] - wcyc[0]);
    end
    vectors++;
    if (last_busy !== wcyc[3]) begin
      miscompares++;
      $display("FAIL single_busy_fall: last busy cycle %0d, required %0d", last_busy, wcyc[3]);
    end
    vectors++;
    if (cnt0 !== 16'd1 || cnt1 !== 2'd1) begin
      miscompares++;
      $display("FAIL single_cnt: msb=%0d lsb=%0d, required 1", cnt0, cnt1);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] e[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    push(32'h12345678);
    drain(40, "lsb_first");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b1q[i] !== e[i] || b0q[i] !== e[3-i]) begin
        miscompares++;
        $display("FAIL lsb_first_byte%0d: lsb=%h msb=%h, required lsb=%h msb=%h", i, b1q[i], b0q[i], e[i], e[3-i]);
      end
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 8; k++) push(32'h00010203 + k * 32'h04040404);
    drain(100, "stream");
    vectors++;
    if (b0q.size() !== 32 || b1q.size() !== 32) begin
      miscompares++;
      $display("FAIL stream_count: msb=%0d lsb=%0d bytes, required 32", b0q.size(), b1q.size());
    end
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (b0q[i] !== 8'(i) || b1q[i] !== 8'(i ^ 3)) begin
        miscompares++;
        $display("FAIL stream_byte%0d: msb=%h lsb=%h, required msb=%h lsb=%h", i, b0q[i], b1q[i], 8'(i), 8'(i ^ 3));
      end
    end
    vectors++;
    if (wcyc[31] - wcyc[0] !== 31) begin
      miscompares++;
      $display("FAIL stream_contig: span %0d cycles, required 31", wcyc[31] - wcyc[0]);
    end
    vectors++;
    if (cnt0 !== 16'd8 || cnt1 !== 2'd0) begin
      miscompares++;
      $display("FAIL stream_cnt: msb=%0d lsb=%0d, required 8 and 0", cnt0, cnt1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                          8'h99, 8'hAA, 8'hBB, 8'hCC};
    int n = 0;
    int stall_c;
    int stall_rd = 0;
    do_reset();
    push(32'h11223344);
    push(32'h55667788);
    push(32'h99AABBCC);
    while (b0q.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    out_full = 1'b1;
    stall_c = cyc;
    repeat (5) tick();
    vectors++;
    if (busy0 !== 1'b1 || b0q.size() !== 2) begin
      miscompares++;
      $display("FAIL bp_stalled: busy=%0b bytes=%0d, required busy=1 bytes=2", busy0, b0q.size());
    end
    out_full = 1'b0;
    drain(60, "bp");
    foreach (rdq[i]) if (rdq[i] >= stall_c && rdq[i] < stall_c + 5) stall_rd++;
    vectors++;
    if (full_wr !== 0) begin
      miscompares++;
      $display("FAIL bp_write_while_full: %0d writes, required 0", full_wr);
    end
    vectors++;
    if (stall_rd > 1) begin
      miscompares++;
      $display("FAIL bp_reads_in_stall: %0d reads, required at most 1", stall_rd);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (b0q[i] !== e[i] || b1q[i] !== e[i ^ 3]) begin
        miscompares++;
        $display("FAIL bp_byte%0d: msb=%h lsb=%h, required msb=%h lsb=%h", i, b0q[i], b1q[i], e[i], e[i ^ 3]);
      end
    end
    vectors++;
    if (wcyc[2] - wcyc[1] !== 6 || wcyc[11] - wcyc[2] !== 9) begin
      miscompares++;
      $display("FAIL bp_timing: gap %0d resume span %0d, required 6 and 9", wcyc[2] - wcyc[1], wcyc[11] - wcyc[2]);
    end
    vectors++;
    if (cnt0 !== 16'd3) begin
      miscompares++;
      $display("FAIL bp_cnt: got %0d, required 3", cnt0);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    int n = 0;
    do_reset();
    push(32'hCAFEBABE);
    push(32'hDEADBEEF);
    while (b0q.size() < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    vectors++;
    if (b0q[1] !== 8'hFE || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: byte1=%h busy=%0b, required FE and 1", b0q[1], busy0);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({rd0, wr0, busy0, d0, cnt0} !== 27'd0 || {rd1, wr1, busy1, d1, cnt1} !== 13'd0) begin
      miscompares++;
      $display("FAIL mid_async: rd=%0b wr=%0b busy=%0b data=%h cnt=%0d, required all 0", rd0, wr0, busy0, d0, cnt0);
    end
    clear_obs();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    vectors++;
    if (b0q.size() !== 0 || b1q.size() !== 0 || rdq.size() !== 0) begin
      miscompares++;
      $display("FAIL mid_quiet: %0d bytes %0d reads after release, required 0", b0q.size(), rdq.size());
    end
    push(32'h01020304);
    drain(40, "mid");
    vectors++;
    if (b0q.size() !== 4) begin
      miscompares++;
      $display("FAIL mid_count: %0d bytes, required 4", b0q.size());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b0q[i] !== e[i] || b1q[i] !== e[3-i]) begin
        miscompares++;
        $display("FAIL mid_byte%0d: msb=%h lsb=%h, required msb=%h lsb=%h", i, b0q[i], b1q[i], e[i], e[3-i]);
      end
    end
    vectors++;
    if (cnt0 !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_cnt: got %0d, required 1", cnt0);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] e[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(32'h10203040 + k);
      drain(40, "wrap");
      vectors++;
      if (cnt1 !== e[k] || cnt0 !== 16'(k + 1)) begin
        miscompares++;
        $display("FAIL wrap_cnt%0d: lsb=%0d msb=%0d, required %0d and %0d", k, cnt1, cnt0, e[k], k + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_lsb_first();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
